// File: rtl/pll_lock_monitor.sv
// Frequency-lock monitor: measures the period of an asynchronous feedback clock in refclk cycles
// and declares or drops lock against a programmed expected period within a tolerance window.
module pll_lock_monitor #(
    parameter int W          = 16,
    parameter int LOCK_CNT   = 8,
    parameter int UNLOCK_CNT = 2
) (
    input  logic         refclk,
    input  logic         reset,
    input  logic         enable,
    input  logic         fbclk,
    input  logic [W-1:0] expected_period,
    input  logic [7:0]   tolerance,
    input  logic         clr_sticky,
    output logic [W-1:0] meas_period,
    output logic         meas_valid,
    output logic         locked,
    output logic         no_clock,
    output logic         lost_lock
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int BW = $clog2(UNLOCK_CNT + 1);
    localparam logic [GW-1:0] LOCK_TGT   = GW'(LOCK_CNT);
    localparam logic [BW-1:0] UNLOCK_TGT = BW'(UNLOCK_CNT);
    localparam logic [W-1:0]  CNT_MAX    = {W{1'b1}};

    typedef enum logic [1:0] {IDLE, ACQUIRE, MEASURE, LOCKED} state_t;

    state_t        state_q;
    logic [2:0]    fb_sync_q;
    logic [2:0]    sync_vld_q;
    logic [W-1:0]  cnt_q;
    logic [W-1:0]  cnt_d;
    logic [GW-1:0] good_cnt_q;
    logic [GW-1:0] good_cnt_d;
    logic [BW-1:0] bad_cnt_q;
    logic [BW-1:0] bad_cnt_d;
    logic [W-1:0]  meas_period_q;
    logic          meas_valid_q;
    logic          locked_q;
    logic          no_clock_q;
    logic          lost_lock_q;
    logic          edge_s;
    logic          timeout_s;
    logic          good_s;
    logic [W:0]    period_s;
    logic [W:0]    exp_s;
    logic [W:0]    diff_s;

    // Edge detect, saturating period counter and tolerance window (W+1 bits so nothing wraps).
    // sync_vld_q follows the data through the synchroniser so the zeros left by reset are never
    // mistaken for a low-to-high transition when fbclk is already high at enable.
    always_comb begin
        edge_s     = fb_sync_q[1] & ~fb_sync_q[2] & sync_vld_q[2];
        timeout_s  = (cnt_q == CNT_MAX) && !edge_s;
        cnt_d      = edge_s ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + W'(1));
        period_s   = {1'b0, cnt_q} + (W+1)'(1);
        exp_s      = {1'b0, expected_period};
        diff_s     = (period_s >= exp_s) ? (period_s - exp_s) : (exp_s - period_s);
        good_s     = (diff_s <= (W+1)'(tolerance));
        good_cnt_d = (good_cnt_q == LOCK_TGT) ? good_cnt_q : good_cnt_q + GW'(1);
        bad_cnt_d  = (bad_cnt_q == UNLOCK_TGT) ? bad_cnt_q : bad_cnt_q + BW'(1);
    end

    // Lock FSM with registered outputs; later lost_lock writes override the clear, so a set wins.
    always_ff @(posedge refclk) begin
        if (reset || !enable) begin
            state_q       <= IDLE;
            fb_sync_q     <= 3'b000;
            sync_vld_q    <= 3'b000;
            cnt_q         <= '0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
            meas_period_q <= '0;
            meas_valid_q  <= 1'b0;
            locked_q      <= 1'b0;
            no_clock_q    <= 1'b0;
            lost_lock_q   <= 1'b0;
        end else begin
            fb_sync_q    <= {fb_sync_q[1:0], fbclk};
            sync_vld_q   <= {sync_vld_q[1:0], 1'b1};
            cnt_q        <= cnt_d;
            meas_valid_q <= 1'b0;
            if (edge_s) begin
                no_clock_q <= 1'b0;
            end
            if (clr_sticky) begin
                lost_lock_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    state_q    <= ACQUIRE;
                    good_cnt_q <= '0;
                    bad_cnt_q  <= '0;
                end
                ACQUIRE: begin
                    if (edge_s) begin
                        state_q <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (timeout_s) begin
                        no_clock_q <= 1'b1;
                        good_cnt_q <= '0;
                        state_q    <= ACQUIRE;
                    end else if (edge_s) begin
                        meas_valid_q  <= 1'b1;
                        meas_period_q <= period_s[W-1:0];
                        if (good_s) begin
                            good_cnt_q <= good_cnt_d;
                            if (good_cnt_d == LOCK_TGT) begin
                                state_q   <= LOCKED;
                                locked_q  <= 1'b1;
                                bad_cnt_q <= '0;
                            end
                        end else begin
                            good_cnt_q <= '0;
                        end
                    end
                end
                LOCKED: begin
                    if (timeout_s) begin
                        no_clock_q  <= 1'b1;
                        locked_q    <= 1'b0;
                        lost_lock_q <= 1'b1;
                        good_cnt_q  <= '0;
                        bad_cnt_q   <= '0;
                        state_q     <= ACQUIRE;
                    end else if (edge_s) begin
                        meas_valid_q  <= 1'b1;
                        meas_period_q <= period_s[W-1:0];
                        if (!good_s) begin
                            bad_cnt_q <= bad_cnt_d;
                            if (bad_cnt_d == UNLOCK_TGT) begin
                                state_q     <= MEASURE;
                                locked_q    <= 1'b0;
                                lost_lock_q <= 1'b1;
                                good_cnt_q  <= '0;
                                bad_cnt_q   <= '0;
                            end
                        end else begin
                            bad_cnt_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign meas_period = meas_period_q;
    assign meas_valid  = meas_valid_q;
    assign locked      = locked_q;
    assign no_clock    = no_clock_q;
    assign lost_lock   = lost_lock_q;

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Directed bench for pll_lock_monitor: feedback clock is generated in lock-step with refclk so
// every measured period is known exactly; a queue of one-off periods injects bad measurements.
module tb_pll_lock_monitor;

    logic        refclk;
    logic        reset;
    logic        enable;
    logic        fbclk;
    logic [15:0] expected_period;
    logic [7:0]  tolerance;
    logic        clr_sticky;
    logic [15:0] meas_period;
    logic        meas_valid;
    logic        locked;
    logic        no_clock;
    logic        lost_lock;

    int n_cmp  = 0;
    int n_fail = 0;
    bit fb_run = 1'b1;
    int fb_period = 32;
    int fb_q[$];

    pll_lock_monitor #(.W(16), .LOCK_CNT(8), .UNLOCK_CNT(2)) dut (
        .refclk          (refclk),
        .reset           (reset),
        .enable          (enable),
        .fbclk           (fbclk),
        .expected_period (expected_period),
        .tolerance       (tolerance),
        .clr_sticky      (clr_sticky),
        .meas_period     (meas_period),
        .meas_valid      (meas_valid),
        .locked          (locked),
        .no_clock        (no_clock),
        .lost_lock       (lost_lock)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Feedback clock: each period starts with a rising edge; queued periods take precedence.
    initial begin : fb_gen
        int p;
        fbclk = 1'b0;
        forever begin
            if (!fb_run) begin
                fbclk = 1'b0;
                @(negedge refclk);
            end else begin
                p = (fb_q.size() > 0) ? fb_q.pop_front() : fb_period;
                fbclk = 1'b1;
                repeat (p / 2) @(negedge refclk);
                fbclk = 1'b0;
                repeat (p - p / 2) @(negedge refclk);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_mv(input string tag, input int bound);
        int k;
        k = 0;
        do begin
            @(negedge refclk);
            k++;
        end while (meas_valid !== 1'b1 && k < bound);
        check({tag, "_mv"}, {31'd0, meas_valid}, 32'd1);
    endtask

    task automatic step(input string tag, input int per, input logic lk, input logic ll);
        wait_mv(tag, 100);
        check({tag, "_period"}, {16'd0, meas_period}, per);
        check({tag, "_locked"}, {31'd0, locked}, {31'd0, lk});
        check({tag, "_lost"}, {31'd0, lost_lock}, {31'd0, ll});
    endtask

    task automatic relock(input string tag, input logic ll);
        for (int i = 0; i < 8; i++) begin
            step(tag, 32, (i == 7), ll);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {12'd0, meas_period, meas_valid, locked, no_clock, lost_lock}, 32'd0);
    endtask

    task automatic clr_pulse(input string tag);
        @(negedge refclk);
        clr_sticky = 1'b1;
        @(negedge refclk);
        clr_sticky = 1'b0;
        check(tag, {31'd0, lost_lock}, 32'd0);
    endtask

    initial begin : stim
        int k;
        reset           = 1'b1;
        enable          = 1'b1;
        expected_period = 16'd32;
        tolerance       = 8'd1;
        clr_sticky      = 1'b0;

        // 1: reset with fbclk toggling, then idle with enable low
        repeat (5) begin
            @(negedge refclk);
            check_zero("reset_outputs");
        end
        reset  = 1'b0;
        enable = 1'b0;
        repeat (40) begin
            @(negedge refclk);
            check_zero("disabled_outputs");
        end

        // 2: acquisition and lock on the 8th measurement
        enable = 1'b1;
        relock("acquire", 1'b0);

        // 3: one bad period is forgiven, two consecutive drop lock
        fb_q.push_back(40);
        step("one_bad_a", 32, 1'b1, 1'b0);
        step("one_bad_b", 40, 1'b1, 1'b0);
        step("one_bad_c", 32, 1'b1, 1'b0);
        fb_q.push_back(40);
        fb_q.push_back(40);
        step("two_bad_a", 32, 1'b1, 1'b0);
        step("two_bad_b", 40, 1'b1, 1'b0);
        step("two_bad_c", 40, 1'b0, 1'b1);
        // a bad period while measuring restarts the good count
        fb_q.push_back(32);
        fb_q.push_back(32);
        fb_q.push_back(40);
        step("gc_reset_a", 32, 1'b0, 1'b1);
        step("gc_reset_b", 32, 1'b0, 1'b1);
        step("gc_reset_c", 32, 1'b0, 1'b1);
        step("gc_reset_d", 40, 1'b0, 1'b1);
        relock("relock_gc", 1'b1);
        clr_pulse("clr_sticky");
        check("clr_keeps_lock", {31'd0, locked}, 32'd1);

        // 5: tolerance window edges
        fb_q.push_back(33);
        fb_q.push_back(33);
        step("tol33_a", 32, 1'b1, 1'b0);
        step("tol33_b", 33, 1'b1, 1'b0);
        step("tol33_c", 33, 1'b1, 1'b0);
        fb_q.push_back(31);
        fb_q.push_back(31);
        step("tol31_a", 32, 1'b1, 1'b0);
        step("tol31_b", 31, 1'b1, 1'b0);
        step("tol31_c", 31, 1'b1, 1'b0);
        fb_q.push_back(34);
        fb_q.push_back(34);
        step("tol34_a", 32, 1'b1, 1'b0);
        step("tol34_b", 34, 1'b1, 1'b0);
        step("tol34_c", 34, 1'b0, 1'b1);
        relock("relock34", 1'b1);
        fb_q.push_back(30);
        fb_q.push_back(30);
        step("tol30_a", 32, 1'b1, 1'b1);
        step("tol30_b", 30, 1'b1, 1'b1);
        step("tol30_c", 30, 1'b0, 1'b1);
        relock("relock30", 1'b1);
        tolerance = 8'd0;
        fb_q.push_back(33);
        fb_q.push_back(33);
        step("tol0_a", 32, 1'b1, 1'b1);
        step("tol0_b", 33, 1'b1, 1'b1);
        step("tol0_c", 33, 1'b0, 1'b1);
        relock("relock_tol0", 1'b1);
        tolerance = 8'd1;

        // 4: fbclk stops while locked, then restarts
        clr_pulse("clr_before_stop");
        fb_run = 1'b0;
        k = 0;
        do begin
            @(negedge refclk);
            k++;
        end while (no_clock !== 1'b1 && k < 70000);
        check("timeout_no_clock", {31'd0, no_clock}, 32'd1);
        check("timeout_latency", {31'd0, (k >= 65500 && k <= 65540)}, 32'd1);
        check("timeout_locked", {31'd0, locked}, 32'd0);
        check("timeout_lost", {31'd0, lost_lock}, 32'd1);
        fb_run = 1'b1;
        k = 0;
        do begin
            @(negedge refclk);
            k++;
        end while (no_clock !== 1'b0 && k < 40);
        check("restart_no_clock", {31'd0, no_clock}, 32'd0);
        check("restart_locked", {31'd0, locked}, 32'd0);
        check("restart_mv", {31'd0, meas_valid}, 32'd0);
        relock("relock_restart", 1'b1);

        // 6: set beats a coincident clear, then enable dropped while locked
        @(negedge refclk);
        clr_sticky = 1'b1;
        @(negedge refclk);
        check("clr_held", {31'd0, lost_lock}, 32'd0);
        fb_q.push_back(40);
        fb_q.push_back(40);
        step("set_wins_a", 32, 1'b1, 1'b0);
        step("set_wins_b", 40, 1'b1, 1'b0);
        step("set_wins_c", 40, 1'b0, 1'b1);
        @(negedge refclk);
        check("clr_after_set", {31'd0, lost_lock}, 32'd0);
        clr_sticky = 1'b0;
        relock("relock_clr", 1'b0);
        fb_q.push_back(40);
        fb_q.push_back(40);
        step("drop_a", 32, 1'b1, 1'b0);
        step("drop_b", 40, 1'b1, 1'b0);
        step("drop_c", 40, 1'b0, 1'b1);
        relock("relock_drop", 1'b1);
        repeat (10) @(negedge refclk);
        enable = 1'b0;
        @(negedge refclk);
        check_zero("disable_next_cycle");
        repeat (20) begin
            @(negedge refclk);
            check_zero("disable_hold");
        end
        enable = 1'b1;
        relock("reenable", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
